// File: rtl/dzcpu_useq_if.sv
// dzcpu_useq_if: bundle between the sequencer and its memory port, flow LUTs, micro-op ROM and datapath.
// The master modport is the sequencer; the slave modport is the surrounding core.
interface dzcpu_useq_if #(
   parameter int UOP_W  = 13,
   parameter int FLOW_W = 8
);
   logic              iStall;
   logic [7:0]        iMemData;
   logic              iFlagZ;
   logic [FLOW_W-1:0] iFlowIdx;
   logic [FLOW_W-1:0] iCbFlowIdx;
   logic [UOP_W-1:0]  iUop;
   logic [7:0]        oMop;
   logic [FLOW_W-1:0] oUopAddr;
   logic [UOP_W-1:0]  oUop;
   logic              oUopValid;
   logic              oPcInc;
   logic              oFlagsUpdate;
   logic              oMopDone;
   logic              oUopOverrun;

   modport master (
      input  iStall, iMemData, iFlagZ, iFlowIdx, iCbFlowIdx, iUop,
      output oMop, oUopAddr, oUop, oUopValid, oPcInc, oFlagsUpdate, oMopDone, oUopOverrun
   );

   modport slave (
      output iStall, iMemData, iFlagZ, iFlowIdx, iCbFlowIdx, iUop,
      input  oMop, oUopAddr, oUop, oUopValid, oPcInc, oFlagsUpdate, oMopDone, oUopOverrun
   );
endinterface

// File: rtl/dzcpu_useq.sv
// dzcpu_useq: latches opcode bytes, walks the micro-op ROM from the LUT flow index and issues registered uops.
// Defining DZCPU_USEQ_WATCHDOG_EN bounds every macro-op to 64 uops and raises a sticky overrun flag.
module dzcpu_useq #(
   parameter int UOP_W  = 13,
   parameter int FLOW_W = 8
) (
   input  logic         iClock,
   input  logic         iReset,
   dzcpu_useq_if.master bus
);
   localparam int PL_W = UOP_W - 4;

   localparam logic [3:0] FC_OP           = 4'd0;
   localparam logic [3:0] FC_NOP          = 4'd1;
   localparam logic [3:0] FC_UPDATE_FLAGS = 4'd2;
   localparam logic [3:0] FC_INC          = 4'd3;
   localparam logic [3:0] FC_EOF          = 4'd4;
   localparam logic [3:0] FC_INC_EOF      = 4'd5;
   localparam logic [3:0] FC_EOF_FU       = 4'd6;
   localparam logic [3:0] FC_INC_EOF_FU   = 4'd7;
   localparam logic [3:0] FC_INC_EOF_Z    = 4'd8;
   localparam logic [3:0] FC_INC_EOF_NZ   = 4'd9;

   localparam logic [PL_W-1:0] PL_JCB = PL_W'(9'h0CB);

   typedef enum logic [1:0] {
      FETCH    = 2'd0,
      DECODE   = 2'd1,
      CBDECODE = 2'd2,
      EXEC     = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic [FLOW_W-1:0] upc_q, upc_d;
   logic [7:0]        mop_q, mop_d;
   logic [UOP_W-1:0]  uop_q, uop_d;
   logic              uopValid_q, uopValid_d;
   logic              pcInc_q, pcInc_d;
   logic              flagsUpdate_q, flagsUpdate_d;
   logic              mopDone_q, mopDone_d;

   logic [3:0]        flowCode;
   logic              isJcb;
   logic              wdForce;
   logic              flowEof;
   logic              jcbTaken;

   assign flowCode = bus.iUop[UOP_W-1 -: 4];
   assign isJcb    = (bus.iUop[PL_W-1:0] == PL_JCB);

   always_ff @(posedge iClock or negedge iReset) begin
      if (!iReset) begin
         state_q       <= FETCH;
         upc_q         <= '0;
         mop_q         <= '0;
         uop_q         <= '0;
         uopValid_q    <= 1'b0;
         pcInc_q       <= 1'b0;
         flagsUpdate_q <= 1'b0;
         mopDone_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         upc_q         <= upc_d;
         mop_q         <= mop_d;
         uop_q         <= uop_d;
         uopValid_q    <= uopValid_d;
         pcInc_q       <= pcInc_d;
         flagsUpdate_q <= flagsUpdate_d;
         mopDone_q     <= mopDone_d;
      end
   end

   // A stall freezes all state and suppresses the pulses that this cycle would otherwise register.
   always_comb begin
      state_d       = state_q;
      upc_d         = upc_q;
      mop_d         = mop_q;
      uop_d         = uop_q;
      uopValid_d    = 1'b0;
      pcInc_d       = 1'b0;
      flagsUpdate_d = 1'b0;
      mopDone_d     = 1'b0;
      flowEof       = 1'b0;
      jcbTaken      = 1'b0;
      if (!bus.iStall) begin
         unique case (state_q)
            FETCH: begin
               mop_d   = bus.iMemData;
               state_d = DECODE;
            end
            DECODE: begin
               upc_d   = bus.iFlowIdx;
               state_d = EXEC;
            end
            CBDECODE: begin
               upc_d   = bus.iCbFlowIdx;
               state_d = EXEC;
            end
            EXEC: begin
               uop_d      = bus.iUop;
               uopValid_d = 1'b1;
               case (flowCode)
                  FC_UPDATE_FLAGS: flagsUpdate_d = 1'b1;
                  FC_INC:          pcInc_d = 1'b1;
                  FC_EOF:          flowEof = 1'b1;
                  FC_INC_EOF: begin
                     pcInc_d = 1'b1;
                     flowEof = 1'b1;
                  end
                  FC_EOF_FU: begin
                     flagsUpdate_d = 1'b1;
                     flowEof       = 1'b1;
                  end
                  FC_INC_EOF_FU: begin
                     pcInc_d       = 1'b1;
                     flagsUpdate_d = 1'b1;
                     flowEof       = 1'b1;
                  end
                  FC_INC_EOF_Z: begin
                     pcInc_d = 1'b1;
                     flowEof = bus.iFlagZ;
                  end
                  FC_INC_EOF_NZ: begin
                     pcInc_d = 1'b1;
                     flowEof = !bus.iFlagZ;
                  end
                  default: ;
               endcase
               // A watchdog-forced end of flow overrides both the flow code and a CB jump.
               if (wdForce) begin
                  flowEof = 1'b1;
               end
               jcbTaken = isJcb && !wdForce;
               if (jcbTaken) begin
                  mop_d   = bus.iMemData;
                  state_d = CBDECODE;
               end
               if (flowEof && !jcbTaken) begin
                  state_d   = FETCH;
                  mopDone_d = 1'b1;
               end else begin
                  upc_d = upc_q + FLOW_W'(1);
               end
            end
         endcase
      end
   end

`ifdef DZCPU_USEQ_WATCHDOG_EN
   logic [5:0] wdCnt_q, wdCnt_d;
   logic       overrun_q, overrun_d;

   assign wdForce = (wdCnt_q == 6'd63);

   always_ff @(posedge iClock or negedge iReset) begin
      if (!iReset) begin
         wdCnt_q   <= '0;
         overrun_q <= 1'b0;
      end else begin
         wdCnt_q   <= wdCnt_d;
         overrun_q <= overrun_d;
      end
   end

   // Counts uops issued since the last flow-index load; the 64th one is cut short.
   always_comb begin
      wdCnt_d   = wdCnt_q;
      overrun_d = overrun_q;
      if (!bus.iStall) begin
         if (state_q == DECODE || state_q == CBDECODE) begin
            wdCnt_d = '0;
         end else if (state_q == EXEC) begin
            wdCnt_d = wdCnt_q + 6'd1;
            if (wdForce) begin
               overrun_d = 1'b1;
            end
         end
      end
   end

   assign bus.oUopOverrun = overrun_q;
`else
   assign wdForce         = 1'b0;
   assign bus.oUopOverrun = 1'b0;
`endif

   assign bus.oMop         = mop_q;
   assign bus.oUopAddr     = upc_q;
   assign bus.oUop         = uop_q;
   assign bus.oUopValid    = uopValid_q;
   assign bus.oPcInc       = pcInc_q;
   assign bus.oFlagsUpdate = flagsUpdate_q;
   assign bus.oMopDone     = mopDone_q;
endmodule

// File: tb/tb_dzcpu_useq.sv
// tb_dzcpu_useq: table-driven check of the dzcpu microcode sequencer against a hand-built ROM and LUTs.
// Watchdog expectations follow DZCPU_USEQ_WATCHDOG_EN when it is defined for the build.
module tb_dzcpu_useq;
   localparam logic [3:0] FC_OP           = 4'd0;
   localparam logic [3:0] FC_NOP          = 4'd1;
   localparam logic [3:0] FC_UPDATE_FLAGS = 4'd2;
   localparam logic [3:0] FC_INC          = 4'd3;
   localparam logic [3:0] FC_EOF          = 4'd4;
   localparam logic [3:0] FC_INC_EOF      = 4'd5;
   localparam logic [3:0] FC_EOF_FU       = 4'd6;
   localparam logic [3:0] FC_INC_EOF_FU   = 4'd7;
   localparam logic [3:0] FC_INC_EOF_Z    = 4'd8;
   localparam logic [3:0] FC_INC_EOF_NZ   = 4'd9;
   localparam logic [8:0] PL_JCB          = 9'h0CB;

`ifdef DZCPU_USEQ_WATCHDOG_EN
   localparam bit WD = 1'b1;
`else
   localparam bit WD = 1'b0;
`endif

   typedef struct {
      logic        stall;
      logic [7:0]  mem;
      logic        z;
      logic        v;
      logic        inc;
      logic        fu;
      logic        done;
      logic [7:0]  addr;
      logic [7:0]  mop;
      logic [12:0] uop;
   } vec_t;

   logic iClock = 1'b0;
   logic iReset = 1'b0;
   int   vecCount = 0;
   int   missCount = 0;
   vec_t vecs[$];

   logic [12:0] rom     [256];
   logic [7:0]  mainLut [256];
   logic [7:0]  cbLut   [256];

   always #5 iClock = ~iClock;

   dzcpu_useq_if #(.UOP_W(13), .FLOW_W(8)) bus ();

   dzcpu_useq #(.UOP_W(13), .FLOW_W(8)) dut (
      .iClock (iClock),
      .iReset (iReset),
      .bus    (bus)
   );

   assign bus.iUop       = rom[bus.oUopAddr];
   assign bus.iFlowIdx   = mainLut[bus.oMop];
   assign bus.iCbFlowIdx = cbLut[bus.oMop];

   function automatic logic [12:0] mk(input logic [3:0] fc, input logic [8:0] pl);
      return {fc, pl};
   endfunction

   task automatic addVec(input int s, input int m, input int z, input int v, input int i,
                         input int f, input int d, input int a, input int o, input logic [12:0] u);
      vec_t r;
      r.stall = 1'(s);
      r.mem   = 8'(m);
      r.z     = 1'(z);
      r.v     = 1'(v);
      r.inc   = 1'(i);
      r.fu    = 1'(f);
      r.done  = 1'(d);
      r.addr  = 8'(a);
      r.mop   = 8'(o);
      r.uop   = u;
      vecs.push_back(r);
   endtask

   // Drives one cycle of inputs and returns just after the active edge.
   task automatic applyStimulus(input logic stall, input logic [7:0] mem, input logic z);
      bus.iStall   = stall;
      bus.iMemData = mem;
      bus.iFlagZ   = z;
      @(posedge iClock);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic v, input logic inc, input logic fu,
                              input logic done, input logic ovr, input logic [7:0] addr,
                              input logic [7:0] mop, input logic [12:0] uop, input logic chkUop);
      logic ok;
      vecCount++;
      ok = (bus.oUopValid === v) && (bus.oPcInc === inc) && (bus.oFlagsUpdate === fu) &&
           (bus.oMopDone === done) && (bus.oUopOverrun === ovr) && (bus.oUopAddr === addr) &&
           (bus.oMop === mop) && (!chkUop || bus.oUop === uop);
      if (!ok) begin
         missCount++;
         $display("[TB] FAIL %s: got v=%b inc=%b fu=%b done=%b ovr=%b addr=%0d mop=%h uop=%h, expected v=%b inc=%b fu=%b done=%b ovr=%b addr=%0d mop=%h uop=%h",
                  name, bus.oUopValid, bus.oPcInc, bus.oFlagsUpdate, bus.oMopDone, bus.oUopOverrun,
                  bus.oUopAddr, bus.oMop, bus.oUop, v, inc, fu, done, ovr, addr, mop, uop);
      end
   endtask

   initial begin
      logic [7:0] expAddr;
      logic       expEnd;
      bus.iStall   = 1'b0;
      bus.iMemData = 8'h00;
      bus.iFlagZ   = 1'b0;

      for (int i = 0; i < 256; i++) begin
         rom[i]     = mk(FC_OP, {1'b1, 8'(i)});
         mainLut[i] = 8'd0;
         cbLut[i]   = 8'd0;
      end
      rom[162] = mk(FC_INC_EOF, 9'h000);
      rom[17]  = mk(FC_INC, 9'h011);
      rom[19]  = mk(FC_INC_EOF_Z, 9'h013);
      rom[20]  = mk(FC_UPDATE_FLAGS, 9'h014);
      rom[21]  = mk(4'hC, 9'h015);
      rom[22]  = mk(FC_INC_EOF_FU, 9'h016);
      rom[13]  = mk(FC_NOP, 9'h000);
      rom[15]  = mk(FC_INC_EOF, PL_JCB);
      rom[16]  = mk(FC_EOF_FU, 9'h000);
      rom[30]  = mk(FC_INC_EOF_NZ, 9'h000);
      rom[1]   = mk(FC_EOF, 9'h000);
      rom[48]  = mk(FC_INC, 9'h030);
      rom[51]  = mk(FC_EOF, 9'h000);
      mainLut[8'h00] = 8'd162;
      mainLut[8'h20] = 8'd17;
      mainLut[8'hCB] = 8'd13;
      mainLut[8'h30] = 8'd30;
      mainLut[8'h10] = 8'd254;
      mainLut[8'hCD] = 8'd48;
      mainLut[8'h50] = 8'd170;
      cbLut[8'h7C]   = 8'd16;

      // stall, mem, z | v, inc, fu, done, addr, mop, uop
      addVec(0, 'h00, 0,  0, 0, 0, 0,   0, 'h00, 0);
      addVec(0, 'h5A, 0,  0, 0, 0, 0, 162, 'h00, 0);
      addVec(0, 'h5A, 0,  1, 1, 0, 1, 162, 'h00, mk(FC_INC_EOF, 9'h000));
      addVec(0, 'h20, 1,  0, 0, 0, 0, 162, 'h20, 0);
      addVec(0, 'h5A, 1,  0, 0, 0, 0,  17, 'h20, 0);
      addVec(0, 'h5A, 1,  1, 1, 0, 0,  18, 'h20, mk(FC_INC, 9'h011));
      addVec(0, 'h5A, 1,  1, 0, 0, 0,  19, 'h20, mk(FC_OP, 9'h112));
      addVec(0, 'h5A, 1,  1, 1, 0, 1,  19, 'h20, mk(FC_INC_EOF_Z, 9'h013));
      addVec(0, 'h20, 0,  0, 0, 0, 0,  19, 'h20, 0);
      addVec(0, 'h5A, 0,  0, 0, 0, 0,  17, 'h20, 0);
      addVec(0, 'h5A, 0,  1, 1, 0, 0,  18, 'h20, mk(FC_INC, 9'h011));
      addVec(0, 'h5A, 0,  1, 0, 0, 0,  19, 'h20, mk(FC_OP, 9'h112));
      addVec(0, 'h5A, 0,  1, 1, 0, 0,  20, 'h20, mk(FC_INC_EOF_Z, 9'h013));
      addVec(0, 'h5A, 1,  1, 0, 1, 0,  21, 'h20, mk(FC_UPDATE_FLAGS, 9'h014));
      addVec(0, 'h5A, 1,  1, 0, 0, 0,  22, 'h20, mk(4'hC, 9'h015));
      addVec(0, 'h5A, 1,  1, 1, 1, 1,  22, 'h20, mk(FC_INC_EOF_FU, 9'h016));
      addVec(0, 'hCB, 0,  0, 0, 0, 0,  22, 'hCB, 0);
      addVec(0, 'h5A, 0,  0, 0, 0, 0,  13, 'hCB, 0);
      addVec(0, 'h5A, 0,  1, 0, 0, 0,  14, 'hCB, mk(FC_NOP, 9'h000));
      addVec(0, 'h5A, 0,  1, 0, 0, 0,  15, 'hCB, mk(FC_OP, 9'h10E));
      addVec(0, 'h7C, 0,  1, 1, 0, 0,  16, 'h7C, mk(FC_INC_EOF, PL_JCB));
      addVec(0, 'h5A, 0,  0, 0, 0, 0,  16, 'h7C, 0);
      addVec(0, 'h5A, 0,  1, 0, 1, 1,  16, 'h7C, mk(FC_EOF_FU, 9'h000));
      addVec(0, 'h30, 0,  0, 0, 0, 0,  16, 'h30, 0);
      addVec(0, 'h5A, 0,  0, 0, 0, 0,  30, 'h30, 0);
      addVec(0, 'h5A, 0,  1, 1, 0, 1,  30, 'h30, mk(FC_INC_EOF_NZ, 9'h000));
      addVec(0, 'h10, 0,  0, 0, 0, 0,  30, 'h10, 0);
      addVec(0, 'h5A, 0,  0, 0, 0, 0, 254, 'h10, 0);
      addVec(0, 'h5A, 0,  1, 0, 0, 0, 255, 'h10, mk(FC_OP, 9'h1FE));
      addVec(0, 'h5A, 0,  1, 0, 0, 0,   0, 'h10, mk(FC_OP, 9'h1FF));
      addVec(0, 'h5A, 0,  1, 0, 0, 0,   1, 'h10, mk(FC_OP, 9'h100));
      addVec(0, 'h5A, 0,  1, 0, 0, 1,   1, 'h10, mk(FC_EOF, 9'h000));
      addVec(0, 'hCD, 0,  0, 0, 0, 0,   1, 'hCD, 0);
      addVec(0, 'h5A, 0,  0, 0, 0, 0,  48, 'hCD, 0);
      addVec(0, 'h5A, 0,  1, 1, 0, 0,  49, 'hCD, mk(FC_INC, 9'h030));
      addVec(0, 'h5A, 0,  1, 0, 0, 0,  50, 'hCD, mk(FC_OP, 9'h131));
      addVec(1, 'h5A, 0,  0, 0, 0, 0,  50, 'hCD, 0);
      addVec(1, 'h5A, 0,  0, 0, 0, 0,  50, 'hCD, 0);
      addVec(1, 'h5A, 0,  0, 0, 0, 0,  50, 'hCD, 0);
      addVec(0, 'h5A, 0,  1, 0, 0, 0,  51, 'hCD, mk(FC_OP, 9'h132));
      addVec(0, 'h5A, 0,  1, 0, 0, 1,  51, 'hCD, mk(FC_EOF, 9'h000));
      addVec(1, 'h00, 0,  0, 0, 0, 0,  51, 'hCD, 0);

      #3;
      checkOutput("reset_state", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'h00, 13'h0, 1'b1);
      @(posedge iClock);
      @(negedge iClock);
      iReset = 1'b1;

      for (int k = 0; k < vecs.size(); k++) begin
         applyStimulus(vecs[k].stall, vecs[k].mem, vecs[k].z);
         checkOutput($sformatf("vec%0d", k + 1), vecs[k].v, vecs[k].inc, vecs[k].fu, vecs[k].done,
                     1'b0, vecs[k].addr, vecs[k].mop, vecs[k].uop, vecs[k].v);
      end

      // Long all-op flow: cut at the 64th uop only when the watchdog is built in.
      applyStimulus(1'b0, 8'h50, 1'b0);
      checkOutput("wd_fetch", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd51, 8'h50, 13'h0, 1'b0);
      applyStimulus(1'b0, 8'h5A, 1'b0);
      checkOutput("wd_decode", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd170, 8'h50, 13'h0, 1'b0);
      for (int i = 1; i <= 64; i++) begin
         applyStimulus(1'b0, 8'h5A, 1'b0);
         expEnd  = WD && (i == 64);
         expAddr = expEnd ? 8'd233 : 8'(170 + i);
         checkOutput($sformatf("wd_uop%0d", i), 1'b1, 1'b0, 1'b0, expEnd, expEnd, expAddr, 8'h50,
                     mk(FC_OP, {1'b1, 8'(169 + i)}), 1'b1);
      end
`ifdef DZCPU_USEQ_WATCHDOG_EN
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("wd_sticky_fetch", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd233, 8'h00, 13'h0, 1'b0);
      applyStimulus(1'b0, 8'h5A, 1'b0);
      checkOutput("wd_sticky_decode", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd162, 8'h00, 13'h0, 1'b0);
      applyStimulus(1'b0, 8'h5A, 1'b0);
      checkOutput("wd_sticky_exec", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd162, 8'h00,
                  mk(FC_INC_EOF, 9'h000), 1'b1);
`endif
      iReset = 1'b0;
      #1;
      checkOutput("reset_after_wd", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'h00, 13'h0, 1'b1);
      @(negedge iClock);
      iReset = 1'b1;

      // Reset asserted while uop 20 of the jump flow is addressed.
      applyStimulus(1'b0, 8'h20, 1'b0);
      checkOutput("mid_fetch", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'h20, 13'h0, 1'b0);
      applyStimulus(1'b0, 8'h5A, 1'b0);
      checkOutput("mid_decode", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd17, 8'h20, 13'h0, 1'b0);
      applyStimulus(1'b0, 8'h5A, 1'b0);
      applyStimulus(1'b0, 8'h5A, 1'b0);
      applyStimulus(1'b0, 8'h5A, 1'b0);
      checkOutput("mid_at_uop20", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd20, 8'h20,
                  mk(FC_INC_EOF_Z, 9'h013), 1'b1);
      iReset = 1'b0;
      #1;
      checkOutput("mid_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'h00, 13'h0, 1'b1);
      @(negedge iClock);
      iReset = 1'b1;
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("post_fetch", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'h00, 13'h0, 1'b0);
      applyStimulus(1'b0, 8'h5A, 1'b0);
      checkOutput("post_decode", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd162, 8'h00, 13'h0, 1'b0);
      applyStimulus(1'b0, 8'h5A, 1'b0);
      checkOutput("post_exec", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd162, 8'h00,
                  mk(FC_INC_EOF, 9'h000), 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end
endmodule
